// File: rtl/mem_multicycle.sv
// rtl/mem_multicycle.sv - multi-cycle single-port word memory with request/ready handshake
// One access in flight at a time; response is a one-cycle data_valid pulse LATENCY edges after accept.
module mem_multicycle #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH_LOG2 = 12,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  wr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  ready,
  output logic                  data_valid,
  output logic                  resp_wr,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    wr_q, wr_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    ready_q, ready_d;
  logic                    data_valid_q, data_valid_d;
  logic                    resp_wr_q, resp_wr_d;
  logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
  logic                    mem_we;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // Byte-lane bit and bits above the array size alias onto the same word.
  logic addr_unused;
  assign addr_unused = ^{addr[ADDR_WIDTH-1:DEPTH_LOG2+1], addr[0]};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wr_d         = wr_q;
    idx_d        = idx_q;
    wdata_d      = wdata_q;
    ready_d      = ready_q;
    data_valid_d = 1'b0;
    resp_wr_d    = 1'b0;
    data_out_d   = data_out_q;
    mem_we       = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          wr_d    = wr;
          idx_d   = addr[DEPTH_LOG2:1];
          wdata_d = data_in;
          cnt_d   = 4'(LATENCY - 1);
          state_d = BUSY;
          ready_d = 1'b0;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d      = IDLE;
          ready_d      = 1'b1;
          data_valid_d = 1'b1;
          resp_wr_d    = wr_q;
          if (wr_q) mem_we = 1'b1;
          else      data_out_d = mem[idx_q];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      wr_q         <= 1'b0;
      idx_q        <= '0;
      wdata_q      <= '0;
      ready_q      <= 1'b1;
      data_valid_q <= 1'b0;
      resp_wr_q    <= 1'b0;
      data_out_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_q         <= wr_d;
      idx_q        <= idx_d;
      wdata_q      <= wdata_d;
      ready_q      <= ready_d;
      data_valid_q <= data_valid_d;
      resp_wr_q    <= resp_wr_d;
      data_out_q   <= data_out_d;
    end
  end

  // Array is not reset, but a reset edge must still squash a coincident write.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) mem[idx_q] <= wdata_q;
  end

  assign ready      = ready_q;
  assign data_valid = data_valid_q;
  assign resp_wr    = resp_wr_q;
  assign data_out   = data_out_q;

endmodule

// File: tb/tb_mem_multicycle.sv
// tb/tb_mem_multicycle.sv - directed self-checking bench for mem_multicycle
module tb_mem_multicycle;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic en_a, wr_a, ready_a, dv_a, rw_a;
  logic [15:0] addr_a, din_a, dout_a;
  logic en_b, wr_b, ready_b, dv_b, rw_b;
  logic [15:0] addr_b, din_b, dout_b;

  int checks = 0;
  int errors = 0;

  mem_multicycle #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .DEPTH_LOG2(12), .LATENCY(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(en_a), .wr(wr_a), .addr(addr_a), .data_in(din_a),
    .ready(ready_a), .data_valid(dv_a), .resp_wr(rw_a), .data_out(dout_a)
  );

  mem_multicycle #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .DEPTH_LOG2(12), .LATENCY(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(en_b), .wr(wr_b), .addr(addr_b), .data_in(din_b),
    .ready(ready_b), .data_valid(dv_b), .resp_wr(rw_b), .data_out(dout_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, wait for its response, check latency and response fields.
  // Returns sampled in the data_valid cycle so the caller may issue back-to-back.
  task automatic access(input bit sel, input bit w, input logic [15:0] a, input logic [15:0] d,
                        input int lat, input logic [15:0] exp_dout, input string tag);
    int n;
    if (sel) begin en_b = 1'b1; wr_b = w; addr_b = a; din_b = d; end
    else     begin en_a = 1'b1; wr_a = w; addr_a = a; din_a = d; end
    tick();
    if (sel) en_b = 1'b0; else en_a = 1'b0;
    check({tag, " ready_low"}, sel ? ready_b : ready_a, 0);
    n = 0;
    while (!(sel ? dv_b : dv_a) && n < 20) begin
      tick();
      n++;
    end
    check({tag, " latency"}, n, lat);
    check({tag, " ready_high"}, sel ? ready_b : ready_a, 1);
    check({tag, " resp_wr"}, sel ? rw_b : rw_a, {31'd0, w});
    check({tag, " data_out"}, sel ? dout_b : dout_a, exp_dout);
  endtask

  initial begin
    int pulses;
    rst_n = 1'b0;
    en_a = 1'b1; wr_a = 1'b1; addr_a = 16'h0010; din_a = 16'hFFFF;
    en_b = 1'b1; wr_b = 1'b1; addr_b = 16'h0010; din_b = 16'hFFFF;
    repeat (2) tick();
    check("rst ready", ready_a, 1);
    check("rst data_valid", dv_a, 0);
    check("rst resp_wr", rw_a, 0);
    check("rst data_out", dout_a, 0);
    check("rst b data_out", dout_b, 0);
    check("rst b ready", ready_b, 1);
    rst_n = 1'b1;
    en_a = 1'b0; en_b = 1'b0;
    tick();
    check("idle no enable", ready_a, 1);

    access(0, 1, 16'h0040, 16'h5555, 4, 16'h0000, "init40");
    tick();
    access(0, 1, 16'h0020, 16'h7777, 4, 16'h0000, "init20");
    tick();

    access(0, 1, 16'h0010, 16'hBEEF, 4, 16'h0000, "wr10");
    tick();
    check("wr10 pulse end", dv_a, 0);
    access(0, 0, 16'h0010, 16'h0000, 4, 16'hBEEF, "rd10");
    tick();

    // Write issued during BUSY must vanish without trace.
    en_a = 1'b1; wr_a = 1'b0; addr_a = 16'h0010; din_a = 16'h0000;
    tick();
    wr_a = 1'b1; addr_a = 16'h0020; din_a = 16'h1234;
    tick();
    tick();
    en_a = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (dv_a) pulses++;
      tick();
    end
    check("busy ignore pulses", pulses, 1);
    check("busy ignore data_out", dout_a, 16'hBEEF);
    access(0, 0, 16'h0020, 16'h0000, 4, 16'h7777, "rd20");
    tick();

    access(0, 1, 16'h0010, 16'h3333, 4, 16'h7777, "b2b wr");
    access(0, 0, 16'h0010, 16'h0000, 4, 16'h3333, "b2b rd");
    tick();
    check("b2b pulse end", dv_a, 0);

    en_a = 1'b1; wr_a = 1'b1; addr_a = 16'h0040; din_a = 16'hAAAA;
    tick();
    en_a = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort ready", ready_a, 1);
    check("abort data_valid", dv_a, 0);
    check("abort data_out", dout_a, 0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (dv_a) pulses++;
      tick();
    end
    check("abort pulses", pulses, 0);
    access(0, 0, 16'h0040, 16'h0000, 4, 16'h5555, "rd40");
    tick();

    access(1, 1, 16'h2010, 16'hC0DE, 1, 16'h0000, "l1 wr2010");
    tick();
    check("l1 pulse end", dv_b, 0);
    access(1, 1, 16'h0012, 16'hF00D, 1, 16'h0000, "l1 wr0012");
    tick();
    access(1, 0, 16'h0010, 16'h0000, 1, 16'hC0DE, "l1 rd0010");
    tick();
    access(1, 0, 16'h0012, 16'h0000, 1, 16'hF00D, "l1 rd0012");
    tick();
    access(1, 0, 16'h0011, 16'h0000, 1, 16'hC0DE, "l1 rd0011");
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
